irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter BASE, default 32'hFFFF_FF00, memory-mapped base address of the register window.
REQ-002 Parameter N_EXT, default 4, number of external interrupt lines.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 irq_src  input  N_EXT  raw asynchronous external interrupt lines, rising-edge triggered.
REQ-006 mem_ren  input  1  core data-bus read strobe.
REQ-007 mem_wen  input  1  core data-bus write strobe.
REQ-008 mem_addr  input  32  core data-bus byte address.
REQ-009 mem_dout  input  32  core write data.
REQ-010 sel  output  1  high when mem_addr[31:5] == BASE[31:5]; top uses it to mux rdata over data RAM output.
REQ-011 rdata  output  32  register read data; 0 when sel low or mem_ren low.
REQ-012 interrupter  output  1  level interrupt to the core's interrupter input.

Function
REQ-013 Sources: bits [N_EXT-1:0] external lines, bit N_EXT internal timer; priority: lowest index highest.
REQ-014 Register map (offset from BASE): 0x00 STATUS (ro, pending), 0x04 MASK (rw), 0x08 CLEAR (wo, write-1-to-clear pending), 0x0C CAUSE (ro), 0x10 TLOAD (rw), 0x14 TCTRL (rw: bit0 enable, bit1 auto-reload), 0x18 TCOUNT (ro); unmapped offsets read 0, writes ignored.
REQ-015 Writes take effect at the rising edge where sel && mem_wen; reads are combinational from current register state.
REQ-016 Each external line passes a 2-flop synchronizer; a rising edge is s2 & ~s3 (third flop).
REQ-017 Latency: line rising between edges k-1 and k -> pending bit set at edge k+2 -> interrupter high after edge k+3.
REQ-018 Pending bits set regardless of MASK; interrupter registered = |(pending & MASK).
REQ-019 Set and CLEAR on the same bit in the same cycle: set wins, bit stays 1.
REQ-020 CAUSE: bit31 = 1 if any (pending & MASK) nonzero; bits[4:0] = index of highest-priority such source; all 0 otherwise.
REQ-021 Timer: writing TLOAD also loads TCOUNT with the written value.
REQ-022 Timer enabled and TCOUNT != 0: TCOUNT decrements by 1 per cycle.
REQ-023 Timer enabled and TCOUNT == 0: pending[N_EXT] set; if auto-reload TCOUNT <= TLOAD, else TCTRL.enable cleared.
REQ-024 TLOAD = 0 with auto-reload: pending[N_EXT] set every enabled cycle (no lock-up, no wrap to 32'hFFFFFFFF).
REQ-025 TLOAD write and terminal-count in same cycle: TLOAD write wins for TCOUNT; pending still set.
REQ-026 Level held high on an external line generates exactly one pending set until the line returns low.

Reset
REQ-027 On rst high, immediately: synchronizers, pending, MASK, TLOAD, TCTRL, TCOUNT, interrupter all 0.
REQ-028 Reset mid-operation discards pending and counting state; first edge detection after release needs a fresh 0->1 transition after synchronizers fill.

Structure
REQ-029 Package mips_irq_pkg holds register offsets, TCTRL bit positions and the timer source index.
REQ-030 One sub-module irq_sync (2-flop synchronizer + edge detector, one line), instantiated N_EXT times.
REQ-031 No combinational path from irq_src to interrupter or rdata.

Verification
REQ-032 MASK=0x1F, pulse irq_src[2] high 3 cycles -> STATUS=0x04 at edge k+2, interrupter=1 after k+3, CAUSE=0x8000_0002.
REQ-033 Pending[0] and [3] set, MASK=0x08 -> CAUSE=0x8000_0003; write CLEAR=0x08 -> interrupter falls next cycle, STATUS=0x01.
REQ-034 CLEAR=0x02 written in the cycle irq_src[1] edge sets pending -> STATUS bit1 remains 1.
REQ-035 TLOAD=3, TCTRL=0x3 -> pending[4] set every 4 cycles; TCTRL=0x1 -> one set then TCTRL reads 0x0.
REQ-036 Assert rst mid-count with pending=0x11 -> all registers and interrupter read 0 without a clock edge.
REQ-037 Read at BASE+0x1C and at address outside window -> rdata=0; sel low outside window.

Source files
------------

// File: rtl/mips_irq_pkg.sv
// mips_irq_pkg: shared constants for the interrupt controller.
//   - Register offsets within the 32-byte window.
//   - TCTRL bit positions.
//   - CAUSE valid bit position.
//   - Helper that gives the pending/mask index of the internal timer source.
package mips_irq_pkg;

    typedef enum logic [4:0] {
        OfsStatus = 5'h00,
        OfsMask   = 5'h04,
        OfsClear  = 5'h08,
        OfsCause  = 5'h0C,
        OfsTload  = 5'h10,
        OfsTctrl  = 5'h14,
        OfsTcount = 5'h18
    } reg_ofs_e;

    localparam int unsigned TCTRL_EN_BIT    = 0;
    localparam int unsigned TCTRL_AR_BIT    = 1;
    localparam int unsigned CAUSE_VALID_BIT = 31;

    // The timer sits directly above the external lines, so it is always the
    // lowest-priority source.
    function automatic int unsigned timer_src_idx(input int unsigned n_ext);
        return n_ext;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync: synchronizer and rising-edge detector for one external interrupt line.
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   async_i in   raw asynchronous interrupt line
//   rise_o  out  one-cycle pulse when a synchronized 0->1 transition is seen
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic       s1_q, s2_q, s3_q;
    // Tracks which stages hold samples taken since reset release. Without it a
    // line held high through reset would look like a fresh rising edge.
    logic [2:0] fill_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            fill_q <= 3'b000;
        end else begin
            s1_q   <= async_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            fill_q <= {fill_q[1:0], 1'b1};
        end
    end

    assign rise_o = s2_q & ~s3_q & fill_q[2];

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller with an internal down-counting timer.
//   clk         in   system clock, all state on rising edge
//   rst         in   asynchronous active-high reset
//   irq_src     in   N_EXT raw external lines, rising-edge triggered
//   mem_ren     in   data-bus read strobe
//   mem_wen     in   data-bus write strobe
//   mem_addr    in   data-bus byte address
//   mem_dout    in   data-bus write data
//   sel         out  address falls in the 32-byte register window at BASE
//   rdata       out  register read data (0 unless sel && mem_ren)
//   interrupter out  registered level interrupt = |(pending & MASK)
// Sources: bits [N_EXT-1:0] external, bit N_EXT timer; lowest index has priority.
module irq_ctrl
    import mips_irq_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'hFFFF_FF00,
    parameter int unsigned N_EXT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_EXT-1:0] irq_src,
    input  logic             mem_ren,
    input  logic             mem_wen,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_dout,
    output logic             sel,
    output logic [31:0]      rdata,
    output logic             interrupter
);

    localparam int unsigned TimerIdx = timer_src_idx(N_EXT);

    logic [N_EXT-1:0] ext_rise;
    logic [N_EXT:0]   pend_q, pend_d;
    logic [N_EXT:0]   mask_q, mask_d;
    logic [N_EXT:0]   set_vec, clr_vec, active;
    logic [31:0]      tload_q, tload_d;
    logic [31:0]      tcount_q, tcount_d;
    logic             en_q, en_d;
    logic             ar_q, ar_d;
    logic             irq_q, irq_d;
    logic             tfire;
    logic             cause_valid;
    logic [4:0]       cause_idx;
    logic [4:0]       offset;
    logic             wr_en, wr_mask, wr_clear, wr_tload, wr_tctrl;

    // irq_src only reaches pending through these flops, so there is no
    // combinational path to interrupter or rdata.
    for (genvar gi = 0; gi < N_EXT; gi++) begin : g_sync
        irq_sync u_sync (
            .clk     (clk),
            .rst     (rst),
            .async_i (irq_src[gi]),
            .rise_o  (ext_rise[gi])
        );
    end

    // Address decode
    assign sel      = (mem_addr[31:5] == BASE[31:5]);
    assign offset   = mem_addr[4:0];
    assign wr_en    = sel & mem_wen;
    assign wr_mask  = wr_en && (offset == OfsMask);
    assign wr_clear = wr_en && (offset == OfsClear);
    assign wr_tload = wr_en && (offset == OfsTload);
    assign wr_tctrl = wr_en && (offset == OfsTctrl);

    // Timer next state; bus writes are applied last so they override the count.
    always_comb begin
        tload_d  = tload_q;
        tcount_d = tcount_q;
        en_d     = en_q;
        ar_d     = ar_q;
        tfire    = 1'b0;
        if (en_q) begin
            if (tcount_q != 32'd0) begin
                tcount_d = tcount_q - 32'd1;
            end else begin
                tfire = 1'b1;
                if (ar_q) begin
                    tcount_d = tload_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end
        if (wr_tload) begin
            tload_d  = mem_dout;
            tcount_d = mem_dout;
        end
        if (wr_tctrl) begin
            en_d = mem_dout[TCTRL_EN_BIT];
            ar_d = mem_dout[TCTRL_AR_BIT];
        end
    end

    // Pending / mask next state; a new event beats a same-cycle clear.
    always_comb begin
        set_vec                = '0;
        set_vec[N_EXT-1:0]     = ext_rise;
        set_vec[TimerIdx]      = tfire;
        clr_vec                = wr_clear ? mem_dout[N_EXT:0] : '0;
        pend_d                 = (pend_q & ~clr_vec) | set_vec;
        mask_d                 = wr_mask ? mem_dout[N_EXT:0] : mask_q;
        irq_d                  = |(pend_q & mask_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= '0;
            mask_q   <= '0;
            tload_q  <= 32'd0;
            tcount_q <= 32'd0;
            en_q     <= 1'b0;
            ar_q     <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            tload_q  <= tload_d;
            tcount_q <= tcount_d;
            en_q     <= en_d;
            ar_q     <= ar_d;
            irq_q    <= irq_d;
        end
    end

    assign interrupter = irq_q;

    // Highest-priority active source: scan downward so the lowest index wins.
    always_comb begin
        active      = pend_q & mask_q;
        cause_valid = |active;
        cause_idx   = 5'd0;
        for (int i = int'(N_EXT); i >= 0; i--) begin
            if (active[i]) begin
                cause_idx = 5'(i);
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel && mem_ren) begin
            case (offset)
                OfsStatus: rdata = 32'(pend_q);
                OfsMask:   rdata = 32'(mask_q);
                OfsCause: begin
                    rdata[CAUSE_VALID_BIT] = cause_valid;
                    rdata[4:0]             = cause_idx;
                end
                OfsTload:  rdata = tload_q;
                OfsTctrl: begin
                    rdata[TCTRL_EN_BIT] = en_q;
                    rdata[TCTRL_AR_BIT] = ar_q;
                end
                OfsTcount: rdata = tcount_q;
                default:   rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized bus/line traffic checked
// against a behavioural model of the controller.
module tb_irq_ctrl;

    localparam logic [31:0] BASE     = 32'hFFFF_FF00;
    localparam int unsigned NX       = 4;
    localparam logic [4:0]  A_STATUS = 5'h00;
    localparam logic [4:0]  A_MASK   = 5'h04;
    localparam logic [4:0]  A_CLEAR  = 5'h08;
    localparam logic [4:0]  A_CAUSE  = 5'h0C;
    localparam logic [4:0]  A_TLOAD  = 5'h10;
    localparam logic [4:0]  A_TCTRL  = 5'h14;
    localparam logic [4:0]  A_TCOUNT = 5'h18;

    logic          clk = 1'b0;
    logic          rst;
    logic [NX-1:0] irq_src;
    logic          mem_ren, mem_wen;
    logic [31:0]   mem_addr, mem_dout;
    logic          sel;
    logic [31:0]   rdata;
    logic          interrupter;

    int errs   = 0;
    int checks = 0;

    always #10 clk = ~clk;

    irq_ctrl #(.BASE(BASE), .N_EXT(NX)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .mem_ren     (mem_ren),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout),
        .sel         (sel),
        .rdata       (rdata),
        .interrupter (interrupter)
    );

    // ---------------- behavioural model ----------------
    logic [4:0]    m_pend, m_mask;
    logic [31:0]   m_tload, m_tcnt;
    logic          m_en, m_ar, m_irq;
    logic [NX-1:0] m_hist[$];  // line samples taken at each edge since reset release

    function automatic logic in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd32);
    endfunction

    function automatic void model_reset();
        m_pend = '0; m_mask = '0; m_tload = '0; m_tcnt = '0;
        m_en = 1'b0; m_ar = 1'b0; m_irq = 1'b0;
        m_hist.delete();
    endfunction

    function automatic void model_edge();
        logic [4:0]  set_v, n_pend, n_mask;
        logic [31:0] n_tload, n_cnt;
        logic        n_en, n_ar, wr;
        int          n;
        if (rst) begin
            model_reset();
            return;
        end
        // A line event lands two edges after the first sample seeing it high,
        // provided the sample before that (also post-reset) was low.
        set_v = '0;
        n = m_hist.size();
        if (n >= 3) set_v[NX-1:0] = m_hist[n-2] & ~m_hist[n-3];
        m_hist.push_back(irq_src);
        if (m_hist.size() > 3) m_hist.delete(0);
        if (m_en && m_tcnt == 0) set_v[4] = 1'b1;
        wr = mem_wen && in_win(mem_addr);
        n_pend = m_pend;
        if (wr && mem_addr[4:0] == A_CLEAR) n_pend = n_pend & ~mem_dout[4:0];
        n_pend = n_pend | set_v;
        n_mask = (wr && mem_addr[4:0] == A_MASK) ? mem_dout[4:0] : m_mask;
        n_tload = m_tload; n_cnt = m_tcnt; n_en = m_en; n_ar = m_ar;
        if (m_en) begin
            if (m_tcnt != 0) n_cnt = m_tcnt - 1;
            else if (m_ar) n_cnt = m_tload;
            else n_en = 1'b0;
        end
        if (wr && mem_addr[4:0] == A_TLOAD) begin n_tload = mem_dout; n_cnt = mem_dout; end
        if (wr && mem_addr[4:0] == A_TCTRL) begin n_en = mem_dout[0]; n_ar = mem_dout[1]; end
        m_irq = (m_pend & m_mask) != 0;
        m_pend = n_pend; m_mask = n_mask; m_tload = n_tload; m_tcnt = n_cnt;
        m_en = n_en; m_ar = n_ar;
    endfunction

    function automatic logic [31:0] model_read();
        logic [31:0] r;
        logic [4:0]  act;
        r   = '0;
        act = m_pend & m_mask;
        if (mem_ren && in_win(mem_addr)) begin
            case (mem_addr[4:0])
                A_STATUS: r = {27'd0, m_pend};
                A_MASK:   r = {27'd0, m_mask};
                A_CAUSE: begin
                    for (int i = 0; i < 5; i++) begin
                        if (act[i]) begin
                            r = 32'h8000_0000 | i;
                            break;
                        end
                    end
                end
                A_TLOAD:  r = m_tload;
                A_TCTRL:  r = {30'd0, m_ar, m_en};
                A_TCOUNT: r = m_tcnt;
                default:  r = '0;
            endcase
        end
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [4:0] ofs, input logic [31:0] d);
        mem_addr = BASE | 32'(ofs);
        mem_dout = d;
        mem_wen  = 1'b1;
        tick();
        mem_wen  = 1'b0;
    endtask

    task automatic rd(input logic [4:0] ofs, output logic [31:0] v);
        mem_addr = BASE | 32'(ofs);
        mem_ren  = 1'b1;
        #1;
        v        = rdata;
        mem_ren  = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] v;
        #2;
        rd(A_STATUS, v); checks++;
        if (v !== 32'h0) begin errs++; $display("FAIL reset_status got=%h exp=0", v); end
        rd(A_TCOUNT, v); checks++;
        if (v !== 32'h0) begin errs++; $display("FAIL reset_tcount got=%h exp=0", v); end
        checks++;
        if (interrupter !== 1'b0) begin errs++; $display("FAIL reset_irq got=%b exp=0", interrupter); end
        mem_addr = BASE; #1; checks++;
        if (sel !== 1'b1) begin errs++; $display("FAIL reset_sel got=%b exp=1", sel); end
        tick(); tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_ext_latency();
        logic [31:0] v;
        bus_write(A_MASK, 32'h1F);
        irq_src[2] = 1'b1;
        tick(); tick();
        rd(A_STATUS, v); checks++;
        if (v !== 32'h0) begin errs++; $display("FAIL lat_early got=%h exp=0", v); end
        tick();
        irq_src[2] = 1'b0;
        rd(A_STATUS, v); checks++;
        if (v !== 32'h4) begin errs++; $display("FAIL lat_status got=%h exp=4", v); end
        checks++;
        if (interrupter !== 1'b0) begin errs++; $display("FAIL lat_irq_early got=%b exp=0", interrupter); end
        tick(); checks++;
        if (interrupter !== 1'b1) begin errs++; $display("FAIL lat_irq got=%b exp=1", interrupter); end
        rd(A_CAUSE, v); checks++;
        if (v !== 32'h8000_0002) begin errs++; $display("FAIL lat_cause got=%h exp=80000002", v); end
        bus_write(A_CLEAR, 32'h1F);
        tick();
    endtask

    task automatic test_level_hold();
        logic [31:0] v;
        irq_src[1] = 1'b1;
        repeat (4) tick();
        rd(A_STATUS, v); checks++;
        if (v !== 32'h2) begin errs++; $display("FAIL level_set got=%h exp=2", v); end
        bus_write(A_CLEAR, 32'h2);
        repeat (6) tick();
        rd(A_STATUS, v); checks++;
        if (v !== 32'h0) begin errs++; $display("FAIL level_once got=%h exp=0", v); end
        irq_src[1] = 1'b0;
        tick();
    endtask

    task automatic test_cause_clear();
        logic [31:0] v;
        bus_write(A_MASK, 32'h0);
        irq_src = 4'b1001;
        tick();
        irq_src = 4'b0000;
        repeat (3) tick();
        bus_write(A_MASK, 32'h09);
        rd(A_CAUSE, v); checks++;
        if (v !== 32'h8000_0000) begin errs++; $display("FAIL cause_prio got=%h exp=80000000", v); end
        bus_write(A_MASK, 32'h08);
        tick();
        rd(A_CAUSE, v); checks++;
        if (v !== 32'h8000_0003) begin errs++; $display("FAIL cause_3 got=%h exp=80000003", v); end
        bus_write(A_CLEAR, 32'h08);
        rd(A_STATUS, v); checks++;
        if (v !== 32'h1) begin errs++; $display("FAIL clear_status got=%h exp=1", v); end
        checks++;
        if (interrupter !== 1'b1) begin errs++; $display("FAIL clear_irq_hold got=%b exp=1", interrupter); end
        tick(); checks++;
        if (interrupter !== 1'b0) begin errs++; $display("FAIL clear_irq_fall got=%b exp=0", interrupter); end
        rd(A_CAUSE, v); checks++;
        if (v !== 32'h0) begin errs++; $display("FAIL cause_none got=%h exp=0", v); end
        bus_write(A_CLEAR, 32'h1F);
    endtask

    task automatic test_set_clear_collision();
        logic [31:0] v;
        irq_src[1] = 1'b1;
        tick(); tick();
        bus_write(A_CLEAR, 32'h2);
        rd(A_STATUS, v); checks++;
        if (v !== 32'h2) begin errs++; $display("FAIL collide_set_wins got=%h exp=2", v); end
        irq_src[1] = 1'b0;
        bus_write(A_CLEAR, 32'h2);
        rd(A_STATUS, v); checks++;
        if (v !== 32'h0) begin errs++; $display("FAIL collide_clear got=%h exp=0", v); end
    endtask

    task automatic test_timer_autoreload();
        logic [31:0] v, w;
        bus_write(A_MASK, 32'h0);
        bus_write(A_TLOAD, 32'd3);
        rd(A_TCOUNT, v); checks++;
        if (v !== 32'd3) begin errs++; $display("FAIL tload_copy got=%h exp=3", v); end
        bus_write(A_TCTRL, 32'h3);
        for (int i = 1; i <= 12; i++) begin
            bus_write(A_CLEAR, 32'h10);
            rd(A_STATUS, v);
            rd(A_TCOUNT, w);
            checks++;
            if (v !== ((i % 4 == 0) ? 32'h10 : 32'h0)) begin
                errs++; $display("FAIL auto_status i=%0d got=%h", i, v);
            end
            checks++;
            if (w !== 32'((7 - i % 4) % 4)) begin
                errs++; $display("FAIL auto_tcount i=%0d got=%h exp=%0d", i, w, (7 - i % 4) % 4);
            end
        end
    endtask

    task automatic test_timer_oneshot();
        logic [31:0] v;
        bus_write(A_TCTRL, 32'h0);
        bus_write(A_CLEAR, 32'h1F);
        bus_write(A_TLOAD, 32'd2);
        bus_write(A_TCTRL, 32'h1);
        tick(); tick();
        rd(A_TCTRL, v); checks++;
        if (v !== 32'h1) begin errs++; $display("FAIL oneshot_en got=%h exp=1", v); end
        tick();
        rd(A_TCTRL, v); checks++;
        if (v !== 32'h0) begin errs++; $display("FAIL oneshot_off got=%h exp=0", v); end
        rd(A_STATUS, v); checks++;
        if (v !== 32'h10) begin errs++; $display("FAIL oneshot_fire got=%h exp=10", v); end
        bus_write(A_CLEAR, 32'h10);
        repeat (5) tick();
        rd(A_STATUS, v); checks++;
        if (v !== 32'h0) begin errs++; $display("FAIL oneshot_once got=%h exp=0", v); end
    endtask

    task automatic test_tload_zero();
        logic [31:0] v, w;
        bus_write(A_TLOAD, 32'd0);
        bus_write(A_TCTRL, 32'h3);
        for (int i = 1; i <= 4; i++) begin
            bus_write(A_CLEAR, 32'h10);
            rd(A_STATUS, v);
            rd(A_TCOUNT, w);
            checks++;
            if (v !== 32'h10 || w !== 32'h0) begin
                errs++; $display("FAIL zero_reload i=%0d status=%h tcount=%h exp 10/0", i, v, w);
            end
        end
        bus_write(A_TLOAD, 32'd7);
        rd(A_TCOUNT, v); checks++;
        if (v !== 32'd7) begin errs++; $display("FAIL tload_wins got=%h exp=7", v); end
        rd(A_STATUS, v); checks++;
        if (v !== 32'h10) begin errs++; $display("FAIL tload_fire got=%h exp=10", v); end
        tick();
        rd(A_TCOUNT, v); checks++;
        if (v !== 32'd6) begin errs++; $display("FAIL tload_dec got=%h exp=6", v); end
        bus_write(A_TCTRL, 32'h0);
        bus_write(A_CLEAR, 32'h1F);
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic [4:0]  ofs_list[6];
        ofs_list = '{A_STATUS, A_MASK, A_CAUSE, A_TLOAD, A_TCTRL, A_TCOUNT};
        bus_write(A_MASK, 32'h1F);
        bus_write(A_TLOAD, 32'd2);
        bus_write(A_TCTRL, 32'h3);
        irq_src[0] = 1'b1;
        repeat (4) tick();
        bus_write(A_TLOAD, 32'd20);
        rd(A_STATUS, v); checks++;
        if (v !== 32'h11) begin errs++; $display("FAIL mid_status got=%h exp=11", v); end
        tick();
        checks++;
        if (interrupter !== 1'b1) begin errs++; $display("FAIL mid_irq got=%b exp=1", interrupter); end
        rst = 1'b1;
        model_reset();
        #1; checks++;
        if (interrupter !== 1'b0) begin errs++; $display("FAIL rst_irq got=%b exp=0", interrupter); end
        foreach (ofs_list[k]) begin
            rd(ofs_list[k], v); checks++;
            if (v !== 32'h0) begin errs++; $display("FAIL rst_reg ofs=%h got=%h exp=0", ofs_list[k], v); end
        end
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        rd(A_STATUS, v); checks++;
        if (v !== 32'h0) begin errs++; $display("FAIL held_line got=%h exp=0", v); end
        irq_src[0] = 1'b0;
        tick();
        irq_src[0] = 1'b1;
        repeat (3) tick();
        rd(A_STATUS, v); checks++;
        if (v !== 32'h1) begin errs++; $display("FAIL fresh_edge got=%h exp=1", v); end
        irq_src[0] = 1'b0;
        bus_write(A_CLEAR, 32'h1F);
    endtask

    task automatic test_decode();
        bus_write(A_MASK, 32'h1F);
        mem_ren  = 1'b1;
        mem_addr = BASE | 32'h1C; #1; checks++;
        if (sel !== 1'b1 || rdata !== 32'h0) begin
            errs++; $display("FAIL dec_1c sel=%b rdata=%h exp 1/0", sel, rdata);
        end
        mem_addr = BASE - 32'd4; #1; checks++;
        if (sel !== 1'b0 || rdata !== 32'h0) begin
            errs++; $display("FAIL dec_below sel=%b rdata=%h exp 0/0", sel, rdata);
        end
        mem_addr = BASE | 32'h24; #1; checks++;
        if (sel !== 1'b0 || rdata !== 32'h0) begin
            errs++; $display("FAIL dec_bit5 sel=%b rdata=%h exp 0/0", sel, rdata);
        end
        mem_addr = 32'h7FFF_FF04; #1; checks++;
        if (sel !== 1'b0 || rdata !== 32'h0) begin
            errs++; $display("FAIL dec_bit31 sel=%b rdata=%h exp 0/0", sel, rdata);
        end
        mem_ren  = 1'b0;
        mem_addr = BASE | 32'h04; #1; checks++;
        if (rdata !== 32'h0) begin errs++; $display("FAIL dec_noren rdata=%h exp=0", rdata); end
        tick();
    endtask

    task automatic test_random();
        logic [4:0]  ofs;
        logic [31:0] exp_r;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) irq_src[$urandom_range(0, NX - 1)] ^= 1'b1;
            ofs     = 5'($urandom_range(0, 7) * 4);
            mem_ren = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                mem_wen  = 1'b1;
                mem_addr = BASE | 32'(ofs);
                case (ofs)
                    A_TLOAD: mem_dout = 32'($urandom_range(0, 6));
                    A_TCTRL: mem_dout = 32'($urandom_range(0, 3));
                    default: mem_dout = $urandom;
                endcase
            end else begin
                mem_wen  = 1'b0;
                mem_addr = BASE | 32'(ofs);
                if ($urandom_range(0, 7) == 0) mem_addr = mem_addr ^ (32'h1 << $urandom_range(5, 31));
            end
            #1;
            exp_r = model_read();
            checks++;
            if (rdata !== exp_r) begin
                errs++; $display("FAIL rand_rdata c=%0d addr=%h got=%h exp=%h", c, mem_addr, rdata, exp_r);
            end
            checks++;
            if (sel !== in_win(mem_addr)) begin
                errs++; $display("FAIL rand_sel c=%0d addr=%h got=%b", c, mem_addr, sel);
            end
            checks++;
            if (interrupter !== m_irq) begin
                errs++; $display("FAIL rand_irq c=%0d got=%b exp=%b", c, interrupter, m_irq);
            end
            tick();
            mem_wen = 1'b0;
        end
    endtask

    initial begin
        rst      = 1'b1;
        irq_src  = '0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        mem_addr = '0;
        mem_dout = '0;
        model_reset();
        test_reset();
        test_ext_latency();
        test_level_hold();
        test_cause_clear();
        test_set_clear_collision();
        test_timer_autoreload();
        test_timer_oneshot();
        test_tload_zero();
        test_reset_mid();
        test_decode();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
